// File: rtl/orb_frame_reader.sv
// orb_frame_reader: reads 12-bit words from the frame-buffer RAM (1-cycle read latency)
// and emits them as a gap-free MSB-first serial stream, one bit every BIT_DIV clocks.
// SW toggles at each frame start so the packer fills the other buffer half.
// Optional feature: define MANCHESTER_EN for Manchester-coded serOut (default build is NRZ).
module orb_frame_reader #(
    parameter int unsigned FRAME_WORDS = 2048,
    parameter int unsigned BIT_DIV     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [11:0] rdData,
    output logic [10:0] rdAddr,
    output logic        RE,
    output logic        SW,
    output logic        serOut,
    output logic        bitClk,
    output logic        frameSync,
    output logic        busy
);
    localparam int unsigned WW = 12;
    localparam int unsigned AW = 11;
    localparam int unsigned BW = 4;
    localparam int unsigned DW = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;

    localparam logic [AW-1:0] LAST_WORD = AW'(FRAME_WORDS - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(BIT_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF  = DW'(BIT_DIV / 2);
    localparam logic [DW-1:0] DIV_PF    = DW'(1);
    localparam logic [DW-1:0] DIV_CAP   = DW'(2);
    localparam logic [BW-1:0] BIT_MSB   = BW'(WW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SHIFT
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] div, div_nxt;
    logic [BW-1:0] bit_idx, bit_nxt;
    logic [AW-1:0] word_idx, word_nxt;
    logic [WW-1:0] shreg, shreg_nxt;
    logic [WW-1:0] hold;
    logic          hold_en;

    logic [AW-1:0] addr_nxt;
    logic          re_nxt, sw_nxt, ser_nxt, bitclk_nxt, fsync_nxt, busy_nxt;
    logic          shifting, prefetch;

    // Next-state, counters and next registered output values
    always_comb begin
        state_nxt  = state;
        div_nxt    = div;
        bit_nxt    = bit_idx;
        word_nxt   = word_idx;
        shreg_nxt  = shreg;
        hold_en    = 1'b0;
        addr_nxt   = rdAddr;
        re_nxt     = 1'b0;
        sw_nxt     = SW;
        ser_nxt    = 1'b0;
        bitclk_nxt = 1'b0;
        fsync_nxt  = 1'b0;
        busy_nxt   = 1'b0;
        shifting   = 1'b0;
        prefetch   = 1'b0;

        case (state)
            S_IDLE: begin
                if (enable) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                state_nxt = S_LOAD;
            end
            S_LOAD: begin
                // First word goes straight to the shifter; hold keeps a copy
                hold_en   = 1'b1;
                state_nxt = S_SHIFT;
                div_nxt   = '0;
                bit_nxt   = BIT_MSB;
                word_nxt  = '0;
                shreg_nxt = rdData;
            end
            S_SHIFT: begin
                // Prefetched word arrives two clocks into the MSB bit period
                hold_en = (div == DIV_CAP) && (bit_idx == BIT_MSB);
                if (div != DIV_LAST) begin
                    div_nxt = div + DW'(1);
                end else begin
                    div_nxt = '0;
                    if (bit_idx != '0) begin
                        bit_nxt   = bit_idx - BW'(1);
                        shreg_nxt = {shreg[WW-2:0], 1'b0};
                    end else begin
                        bit_nxt   = BIT_MSB;
                        shreg_nxt = hold;
                        if (word_idx != LAST_WORD) begin
                            word_nxt = word_idx + AW'(1);
                        end else begin
                            word_nxt = '0;
                            if (!enable) state_nxt = S_IDLE;
                        end
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        shifting   = (state_nxt == S_SHIFT);
        prefetch   = shifting && (div_nxt == DIV_PF) && (bit_nxt == BIT_MSB);
        busy_nxt   = (state_nxt != S_IDLE);
        re_nxt     = (state_nxt == S_FETCH) || prefetch;
        if (state_nxt == S_FETCH) begin
            addr_nxt = '0;
        end else if (prefetch) begin
            addr_nxt = (rdAddr == LAST_WORD) ? '0 : rdAddr + AW'(1);
        end
        bitclk_nxt = shifting && (div_nxt == '0);
        fsync_nxt  = bitclk_nxt && (bit_nxt == BIT_MSB) && (word_nxt == '0);
        sw_nxt     = SW ^ fsync_nxt;
`ifdef MANCHESTER_EN
        ser_nxt    = shifting && (shreg_nxt[WW-1] ^ (div_nxt >= DIV_HALF));
`else
        ser_nxt    = shifting && shreg_nxt[WW-1];
`endif
    end

    // State and bit/word counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            div      <= '0;
            bit_idx  <= '0;
            word_idx <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_nxt;
            div      <= div_nxt;
            bit_idx  <= bit_nxt;
            word_idx <= word_nxt;
            shreg    <= shreg_nxt;
        end
    end

    // Hold register: sampled from the RAM only on the capture cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold <= '0;
        end else if (hold_en) begin
            hold <= rdData;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdAddr    <= '0;
            RE        <= 1'b0;
            SW        <= 1'b0;
            serOut    <= 1'b0;
            bitClk    <= 1'b0;
            frameSync <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rdAddr    <= addr_nxt;
            RE        <= re_nxt;
            SW        <= sw_nxt;
            serOut    <= ser_nxt;
            bitClk    <= bitclk_nxt;
            frameSync <= fsync_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_orb_frame_reader.sv
// Bench for orb_frame_reader (FRAME_WORDS=4, BIT_DIV=4) with a registered-output RAM model
// that drives random junk on rdData except in the cycle after RE.
// Honours MANCHESTER_EN when the design is built with it.
module tb_orb_frame_reader;
    localparam int unsigned FW = 4;
    localparam int unsigned BD = 4;
    localparam int unsigned WP = 12 * BD;
    localparam int unsigned FP = FW * WP;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [11:0] rdData;
    logic [10:0] rdAddr;
    logic        RE, SW, serOut, bitClk, frameSync, busy;

    orb_frame_reader #(.FRAME_WORDS(FW), .BIT_DIV(BD)) dut (
        .clk(clk), .rst(rst), .enable(enable), .rdData(rdData), .rdAddr(rdAddr),
        .RE(RE), .SW(SW), .serOut(serOut), .bitClk(bitClk), .frameSync(frameSync),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame buffer RAM: 1-cycle registered read, garbage on rdData outside valid cycle
    logic [11:0] mem [FW];
    logic [11:0] ram_q = '0;
    logic [11:0] noise = '0;
    logic        re_d = 1'b0;
    always @(posedge clk) begin
        re_d <= RE;
        if (RE) ram_q <= mem[int'(rdAddr) % FW];
    end
    always @(negedge clk) noise <= 12'($urandom);
    assign rdData = re_d ? ram_q : noise;

    // Reference model: expected outputs from time elapsed since the first bit of a run
    int   m_state = 0;   // 0 idle, 1 fetch, 2 load, 3 streaming
    int   k = 0;         // clocks since first bit of the run
    logic e_busy = 0, e_re = 0, e_ser = 0, e_bclk = 0, e_fs = 0, e_sw = 0;
    logic [10:0] e_addr = '0;
    always @(posedge clk or negedge rst) begin
        int word, bpos, dv;
        logic b;
        if (!rst) begin
            m_state = 0; k = 0;
            e_busy = 0; e_re = 0; e_ser = 0; e_bclk = 0; e_fs = 0; e_sw = 0; e_addr = '0;
        end else begin
            case (m_state)
                0: if (enable) m_state = 1;
                1: m_state = 2;
                2: begin m_state = 3; k = 0; end
                default: begin
                    if (((k + 1) % FP == 0) && !enable) m_state = 0;
                    else k = k + 1;
                end
            endcase
            word = (k / WP) % FW;
            bpos = (k % WP) / BD;
            dv   = k % BD;
            b    = mem[word][11 - bpos];
            e_busy = (m_state != 0);
            e_re   = (m_state == 1) || (m_state == 3 && bpos == 0 && dv == 1);
            e_addr = (m_state == 1) ? 11'(0) : 11'((word + 1) % FW);
            e_bclk = (m_state == 3) && (dv == 0);
            e_fs   = (m_state == 3) && (k % FP == 0);
            if (e_fs) e_sw = ~e_sw;
`ifdef MANCHESTER_EN
            e_ser  = (m_state == 3) && (b ^ (dv >= BD / 2));
`else
            e_ser  = (m_state == 3) && b;
`endif
        end
    end

    // Per-cycle compare plus recording of frame starts and received words
    logic [11:0] cap_sh = '0;
    int          cap_n = 0;
    logic [11:0] got_q[$];
    int          fs_cyc[$];
    logic        fs_sw[$];
    always @(negedge clk) begin
        if (!rst) begin
            cap_n = 0;
        end else begin
            check("busy", busy, e_busy);
            check("RE", RE, e_re);
            if (e_re) check("rdAddr", rdAddr, e_addr);
            check("serOut", serOut, e_ser);
            check("bitClk", bitClk, e_bclk);
            check("frameSync", frameSync, e_fs);
            check("SW", SW, e_sw);
            if (frameSync) begin
                fs_cyc.push_back(cyc);
                fs_sw.push_back(SW);
            end
            if (bitClk) begin
                cap_sh = {cap_sh[10:0], serOut};
                cap_n++;
                if (cap_n == 12) begin
                    got_q.push_back(cap_sh);
                    cap_n = 0;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) tick();
    endtask

    task automatic wait_fs(output int c, input int budget);
        int n;
        n = fs_cyc.size();
        for (int i = 0; i < budget; i++) begin
            tick();
            if (fs_cyc.size() > n) begin
                c = fs_cyc[n];
                return;
            end
        end
        c = -1;
        checks++; errors++;
        $display("FAIL wait_fs: no frameSync within %0d clocks", budget);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) return;
            tick();
        end
        checks++; errors++;
        $display("FAIL wait_idle: busy still high after %0d clocks", budget);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdAddr"}, rdAddr, 0);
        check({tag, "_RE"}, RE, 0);
        check({tag, "_SW"}, SW, 0);
        check({tag, "_serOut"}, serOut, 0);
        check({tag, "_bitClk"}, bitClk, 0);
        check({tag, "_frameSync"}, frameSync, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] lit [4];
        logic [7:0]  pat;
        int c0, fs0, fs1, fs2, fs3, fs4, len;

        lit[0] = 12'hA5C; lit[1] = 12'h001; lit[2] = 12'h800; lit[3] = 12'hFFF;
        for (int i = 0; i < FW; i++) mem[i] = lit[i];

        // Reset state
        #2 rst = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b1;
        repeat (4) tick();

        // Known words, three back-to-back frames
        got_q.delete(); fs_cyc.delete(); fs_sw.delete();
        enable = 1'b1;
        c0 = cyc;
        wait_fs(fs0, 20);
        check("start_latency", 32'(fs0 - c0), 3);

        // Bits 11 and 10 of 0x800 (word 2)
        wait_cyc(fs0 + 2 * WP);
        pat = '0;
        for (int i = 0; i < 8; i++) begin
            pat = {pat[6:0], serOut};
            tick();
        end
`ifdef MANCHESTER_EN
        check("word2_head", pat, 8'b1100_0011);
`else
        check("word2_head", pat, 8'b1111_0000);
`endif

        wait_fs(fs1, FP + 20);
        wait_fs(fs2, FP + 20);
        check("frame_period1", 32'(fs1 - fs0), 192);
        check("frame_period2", 32'(fs2 - fs1), 192);

        // Drop enable during word 1 of the third frame; the frame still completes
        wait_cyc(fs2 + 60);
        enable = 1'b0;
        wait_idle(300);
        check("words_sent", got_q.size(), 12);
        len = (got_q.size() < 12) ? got_q.size() : 12;
        for (int i = 0; i < len; i++) check("word_value", got_q[i], lit[i % 4]);
        check("sw_f0", fs_sw[0], 1);
        check("sw_f1", fs_sw[1], 0);
        check("sw_f2", fs_sw[2], 1);
        check("idle_sw", SW, 1);
        check("idle_ser", serOut, 0);

        // Re-enable from IDLE
        repeat (5) tick();
        c0 = cyc;
        enable = 1'b1;
        wait_fs(fs3, 20);
        check("restart_latency", 32'(fs3 - c0), 3);
        check("restart_sw", fs_sw[fs_sw.size() - 1], 0);

        // Asynchronous reset mid-word (bit 5 of word 2)
        wait_cyc(fs3 + 2 * WP + 5 * BD + 1);
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        repeat (3) tick();
        rst = 1'b1;
        c0 = cyc;
        wait_fs(fs4, 20);
        check("post_rst_latency", 32'(fs4 - c0), 3);
        check("post_rst_sw", fs_sw[fs_sw.size() - 1], 1);
        enable = 1'b0;
        wait_idle(FP + 20);

        // Random contents and random enable activity
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < FW; i++) mem[i] = 12'($urandom);
            enable = 1'b1;
            len = $urandom_range(100, 700);
            for (int i = 0; i < len; i++) begin
                tick();
                enable = ($urandom_range(0, 5) != 0);
            end
            enable = 1'b0;
            wait_idle(FP + 20);
            repeat ($urandom_range(1, 6)) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
